argmax_frame_ctrl: RTL and testbench

Frame-level controller for the network's classification stage: consumes the stream of signed class scores produced by the final fully-connected layer and sequences the running-max search. It emits exactly one class decision per frame through a ready/valid output buffer. It replaces free-running, counter-only argmax sequencing with explicit frame delimiting, back-pressure and error flagging. It sits between the last FC layer and the result/UART reporting logic.

---
 rtl/argmax_frame_ctrl.sv | 135 +++++++++++++
 tb/tb_argmax_frame_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_frame_ctrl.sv
// Frame-delimited running-argmax controller with a ready/valid result buffer.
// Optional macro ARGMAX_TIE_LAST_EN: report the highest index among equal maxima.
module argmax_frame_ctrl #(
   parameter int NUM_CLASS = 10,
   parameter int DW        = 20,
   parameter int CW        = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic signed [DW-1:0] s_data,
   input  logic                 s_last,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [CW-1:0]        o_class,
   output logic signed [DW-1:0] o_score,
   output logic                 o_err
);

   // state | meaning
   // IDLE  | waiting for the first score of a frame
   // ACCUM | running max search over the remaining scores
   // HOLD  | result presented, input back-pressured until accepted
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CLASS - 1);

   state_t                state_q, state_d;
   logic signed [DW-1:0]  max_q, max_d;
   logic [CW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [CW-1:0]         o_class_q, o_class_d;
   logic signed [DW-1:0]  o_score_q, o_score_d;
   logic                  o_err_q, o_err_d;

   logic beat;
   logic win;
   logic cnt_is_last;

   assign s_ready = (state_q != HOLD);
   assign o_valid = (state_q == HOLD);
   assign o_class = o_class_q;
   assign o_score = o_score_q;
   assign o_err   = o_err_q;

   assign beat        = s_valid && s_ready;
   assign cnt_is_last = (cnt_q == LAST_IDX);

`ifdef ARGMAX_TIE_LAST_EN
   assign win = (s_data >= max_q);
`else
   assign win = (s_data > max_q);
`endif

   always_comb begin
      state_d   = state_q;
      max_d     = max_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      o_class_d = o_class_q;
      o_score_d = o_score_q;
      o_err_d   = o_err_q;

      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         o_err_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (beat) begin
                  max_d = s_data;
                  idx_d = '0;
                  cnt_d = CW'(1);
                  if (s_last) begin
                     // single-beat frame is always a length error
                     o_class_d = '0;
                     o_score_d = s_data;
                     o_err_d   = 1'b1;
                     cnt_d     = '0;
                     state_d   = HOLD;
                  end else begin
                     state_d = ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (beat) begin
                  if (win) begin
                     max_d = s_data;
                     idx_d = cnt_q;
                  end
                  cnt_d = cnt_q + CW'(1);
                  if (s_last || cnt_is_last) begin
                     o_class_d = win ? cnt_q : idx_q;
                     o_score_d = win ? s_data : max_q;
                     o_err_d   = !(s_last && cnt_is_last);
                     cnt_d     = '0;
                     state_d   = HOLD;
                  end
               end
            end
            HOLD: begin
               if (o_ready) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         max_q     <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         o_class_q <= '0;
         o_score_q <= '0;
         o_err_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         max_q     <= max_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         o_class_q <= o_class_d;
         o_score_q <= o_score_d;
         o_err_q   <= o_err_d;
      end
   end

endmodule

// File: tb/tb_argmax_frame_ctrl.sv
// Scoreboard bench for argmax_frame_ctrl: directed frames, expected results queued, monitor compares.
module tb_argmax_frame_ctrl;
   localparam int NUM_CLASS = 10;
   localparam int DW        = 20;
   localparam int CW        = 4;

`ifdef ARGMAX_TIE_LAST_EN
   localparam int NOM_CLS = 4;
`else
   localparam int NOM_CLS = 2;
`endif

   logic          clk_in = 1'b0;
   logic          rst_n, flush, s_valid, s_last, o_ready;
   logic          s_ready, o_valid, o_err;
   logic [DW-1:0] s_data, o_score;
   logic [CW-1:0] o_class;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int cls;
      int score;
      int err;
   } res_t;

   res_t exp_q[$];
   res_t mon_r;
   int   fq[$];

   argmax_frame_ctrl #(.NUM_CLASS(NUM_CLASS), .DW(DW), .CW(CW)) dut (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .flush   (flush),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_last  (s_last),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_class (o_class),
      .o_score (o_score),
      .o_err   (o_err)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   function automatic int score_i();
      return int'($signed(o_score));
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int c, input int s, input int e);
      res_t r;
      r.cls = c;
      r.score = s;
      r.err = e;
      exp_q.push_back(r);
   endtask

   task automatic beat(input int v, input logic l, output int acc);
      int t;
      t = 0;
      s_valid = 1'b1;
      s_data  = v[DW-1:0];
      s_last  = l;
      while (!s_ready && t < 100) begin
         @(posedge clk_in); #1;
         t++;
      end
      if (t >= 100) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout: s_ready stuck at %0d, required 1", s_ready);
      end
      @(posedge clk_in); #1;
      acc = cyc;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input int last_at, output int first_acc);
      int a;
      first_acc = 0;
      for (int i = 0; i < fq.size(); i++) begin
         beat(fq[i], (i + 1) == last_at, a);
         if (i == 0) first_acc = a;
      end
   endtask

   task automatic cycle();
      @(posedge clk_in); #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, o_valid, 0);
      chk({tag, "_ready"}, s_ready, 1);
      chk({tag, "_class"}, o_class, 0);
      chk({tag, "_score"}, score_i(), 0);
      chk({tag, "_err"},   o_err, 0);
   endtask

   // Monitor: every accepted result must match the head of the expected queue
   always @(negedge clk_in) begin
      if (rst_n === 1'b1 && o_valid && o_ready && !flush) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: class=%0d score=%0d err=%0d with nothing expected",
                     o_class, score_i(), o_err);
         end else begin
            mon_r = exp_q.pop_front();
            chk("res_class", o_class, mon_r.cls);
            chk("res_score", score_i(), mon_r.score);
            chk("res_err",   o_err, mon_r.err);
         end
      end
   end

   initial begin
      int f1, f2, t;
      rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      s_data = '0; o_ready = 1'b1;
      #3;
      chk_zero("reset");
      #9 rst_n = 1'b1;
      cycle();

      // nominal frame with a tie between index 2 and 4
      fq = '{5, -3, 90, 12, 90, 0, -7, 40, 1, 2};
      push(NOM_CLS, 90, 0);
      send_frame(10, f1);
      chk("nom_latency_valid", o_valid, 1);
      cycle();
      chk("nom_pulse_len", o_valid, 0);

      fq = '{-100, -99, -98, -97, -96, -95, -94, -93, -92, -91};
      push(9, -91, 0);
      send_frame(10, f1);

      fq = '{-42};
      push(0, -42, 1);
      send_frame(1, f1);

      fq = '{3, 8, -1, 6, 7, 2};
      push(1, 8, 1);
      send_frame(6, f1);
      chk("short_end_valid", o_valid, 1);

      // 10 beats without s_last, then beat 11 opens a new two-beat frame
      fq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
      push(8, 9, 1);
      send_frame(0, f1);
      chk("long_end_valid", o_valid, 1);
      fq = '{-5, 20};
      push(1, 20, 1);
      send_frame(2, f1);
      cycle();

      // back-pressure: result held, input refused for 20 cycles
      o_ready = 1'b0;
      fq = '{7, 1, 2, 3, 4, 5, 6, 7, 8, -9};
      push(8, 8, 0);
      send_frame(10, f1);
      s_valid = 1'b1; s_data = 20'd123; s_last = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk("bp_valid", o_valid, 1);
         chk("bp_ready", s_ready, 0);
         chk("bp_class", o_class, 8);
         chk("bp_score", score_i(), 8);
         chk("bp_err",   o_err, 0);
         cycle();
      end
      s_valid = 1'b0; s_last = 1'b0;
      o_ready = 1'b1;
      cycle();
      chk("bp_release_valid", o_valid, 0);
      chk("bp_release_ready", s_ready, 1);

      // flush on beat 5 drops the frame
      fq = '{50, 60, 70, 80};
      send_frame(0, f1);
      s_valid = 1'b1; s_data = 20'd999; flush = 1'b1;
      cycle();
      flush = 1'b0; s_valid = 1'b0;
      chk("flush_valid", o_valid, 0);
      chk("flush_ready", s_ready, 1);
      cycle();
      chk("flush_quiet", o_valid, 0);
      fq = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, 100};
      push(9, 100, 0);
      send_frame(10, f1);
      cycle();

      // async reset mid-ACCUM
      fq = '{1, 2, 3};
      send_frame(0, f1);
      #1 rst_n = 1'b0;
      #1 chk_zero("rst_accum");
      rst_n = 1'b1;
      cycle();

      // async reset during HOLD; that result is discarded
      o_ready = 1'b0;
      fq = '{5, -3, 90, 12, 90, 0, -7, 40, 1, 2};
      send_frame(10, f1);
      chk("hold_before_rst", o_valid, 1);
      #1 rst_n = 1'b0;
      #1 chk_zero("rst_hold");
      rst_n = 1'b1;
      o_ready = 1'b1;
      cycle();

      // back-to-back frames: NUM_CLASS+1 cycles per frame
      fq = '{5, -3, 90, 12, 90, 0, -7, 40, 1, 2};
      push(NOM_CLS, 90, 0);
      send_frame(10, f1);
      fq = '{-100, -99, -98, -97, -96, -95, -94, -93, -92, -91};
      push(9, -91, 0);
      send_frame(10, f2);
      chk("b2b_period", f2 - f1, NUM_CLASS + 1);

      t = 0;
      while (exp_q.size() != 0 && t < 50) begin
         cycle();
         t++;
      end
      chk("drain_pending", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
